// File: rtl/ofm_pack_writer.sv
`default_nettype none
// ============================================================================
// Module      : ofm_pack_writer
// Description : Captures sixteen post-ReLU6 OFM lanes per completed window and
//               writes them as four packed 32-bit words into the OFM BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module ofm_pack_writer #(
    parameter int NUM_LANES     = 16,
    parameter int WORDS_PER_PIX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [15:0]            total_pix,
    input  logic [NUM_LANES-1:0]   valid_in,
    input  logic [NUM_LANES*8-1:0] ofm_in,
    output logic                   wr_en,
    output logic [31:0]            wr_addr,
    output logic [31:0]            wr_data,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err_overrun,
    output logic                   err_partial
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]           c_last_word = 2'(WORDS_PER_PIX - 1);
    localparam logic [NUM_LANES-1:0] c_all_valid = '1;

    state_t                   r_state;
    logic [31:0]              r_base;
    logic [15:0]              r_total;
    logic [15:0]              r_pix_cnt;
    logic [1:0]               r_word_cnt;
    logic [NUM_LANES*8-1:0]   r_hold;

    logic                     w_full;
    logic                     w_partial;
    logic [1:0]               w_next_word;
    logic [15:0]              w_pix_next;

    assign w_full      = (valid_in == c_all_valid);
    assign w_partial   = (valid_in != '0) && !w_full;
    assign w_next_word = r_word_cnt + 2'd1;
    assign w_pix_next  = r_pix_cnt + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_total     <= '0;
            r_pix_cnt   <= '0;
            r_word_cnt  <= '0;
            r_hold      <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_overrun <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Restart wins over anything else, including a same-cycle group.
                r_base      <= base_addr;
                r_total     <= total_pix;
                r_pix_cnt   <= '0;
                r_word_cnt  <= '0;
                err_overrun <= 1'b0;
                err_partial <= 1'b0;
                wr_en       <= 1'b0;
                busy        <= 1'b1;
                if (total_pix == 16'd0) begin
                    r_state  <= S_DONE;
                    done     <= 1'b1;
                    in_ready <= 1'b0;
                end else begin
                    r_state  <= S_WAIT;
                    in_ready <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_full) err_overrun <= 1'b1;
                    end
                    S_WAIT: begin
                        if (w_full) begin
                            // Word 0 goes straight out from the live input.
                            r_hold     <= ofm_in;
                            r_word_cnt <= '0;
                            wr_en      <= 1'b1;
                            wr_addr    <= r_base + {14'd0, r_pix_cnt, 2'b00};
                            wr_data    <= ofm_in[31:0];
                            in_ready   <= 1'b0;
                            r_state    <= S_DRAIN;
                        end else if (w_partial) begin
                            err_partial <= 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (w_full) err_overrun <= 1'b1;
                        if (r_word_cnt != c_last_word) begin
                            r_word_cnt <= w_next_word;
                            wr_addr    <= wr_addr + 32'd1;
                            wr_data    <= r_hold[{w_next_word, 5'b00000} +: 32];
                        end else begin
                            wr_en     <= 1'b0;
                            r_pix_cnt <= w_pix_next;
                            if (w_pix_next == r_total) begin
                                r_state <= S_DONE;
                                done    <= 1'b1;
                            end else begin
                                r_state  <= S_WAIT;
                                in_ready <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (w_full) err_overrun <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ofm_pack_writer.md
# ofm_pack_writer

Write-back end of the MB_CONV compute path: captures the sixteen 8-bit post-ReLU6 OFM lanes when the PE cluster flags a completed window. It packs the 16 bytes into four 32-bit words and writes them sequentially into a word-addressed OFM BRAM through a single write port (addr / wr_rd_en / data_in style). It sits between the PE cluster's ReLU6 outputs and the OFM BRAM, and reports completion of a layer tile to the controller.

## Interface
Parameters:
- NUM_LANES, 16, number of PE output lanes; fixed at 16 for this revision.
- WORDS_PER_PIX, 4, 32-bit words written per captured pixel; equals NUM_LANES/4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; latches base_addr and total_pix, clears counters, enters WAIT.
- base_addr  in  32  first OFM BRAM word address of the tile.
- total_pix  in  16  number of pixel groups expected for the tile.
- valid_in  in  16  per-lane valid from PE cluster.
- ofm_in  in  128  lane i at bits [8i+7:8i].
- wr_en  out  1  OFM BRAM write enable.
- wr_addr  out  32  OFM BRAM word address.
- wr_data  out  32  packed write data.
- in_ready  out  1  high only in WAIT.
- busy  out  1  high in WAIT, DRAIN, DONE.
- done  out  1  one-cycle pulse when the tile is complete.
- err_overrun  out  1  sticky; valid group arrived when not in WAIT.
- err_partial  out  1  sticky; valid_in nonzero but not 16'hFFFF.

## Operation
- States: IDLE, WAIT, DRAIN, DONE.
- IDLE: wr_en=0. On start, latch inputs, clear pix_cnt, word_cnt, and both error flags. Go to WAIT, or go to DONE if total_pix==0.
- WAIT: when valid_in==16'hFFFF, capture ofm_in into a 128-bit holding register, clear word_cnt, and go to DRAIN.
- WAIT, partial valid: valid_in nonzero and not all ones sets err_partial. No capture; stay in WAIT.
- DRAIN: wr_en=1 each cycle for word_cnt=0..3.
  - wr_addr = base_addr + 4*pix_cnt + word_cnt, modulo 2^32.
  - wr_data = {lane4k+3, lane4k+2, lane4k+1, lane4k}, with k=word_cnt.
  - After word 3, increment pix_cnt. Go to DONE if pix_cnt+1==total_pix, else WAIT.
- DONE: done=1 for exactly one cycle, then IDLE.
- An all-ones valid_in in IDLE, DRAIN, or DONE sets err_overrun. The group is dropped; the holding register is untouched.
- start outside IDLE aborts the current tile and restarts as above. Same-cycle valid_in is ignored, with no error flagged.
- A write in progress in the start cycle is cut. wr_en is 0 from the next cycle until the new tile drains.
- pix_cnt is 16 bits and never wraps, since the tile terminates at total_pix.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=0, done=0, err_overrun=0, err_partial=0, state=IDLE.
- All outputs are registered.
- Capture edge N (WAIT with valid all ones): word 0 appears in cycle N+1, word 3 in cycle N+4.
- After word 3 (cycle N+4), in_ready returns in cycle N+5, or done pulses in N+5.
- Minimum spacing between accepted groups is 5 cycles.
- The PE cluster's window period (≥9 cycles for a 3x3 kernel) never triggers an overrun in normal use.
- start edge S: in_ready=1 in S+1, or done=1 in S+1 if total_pix==0.
- Reset asserted mid-DRAIN: wr_en drops asynchronously to 0, and no further words are written after deassertion.

## Test plan
- Single pixel: start, base_addr=0x100, total_pix=1, lane i=i+1. Expect writes 0x100=0x04030201, 0x101=0x08070605, 0x102=0x0C0B0A09, 0x103=0x100F0E0D on 4 consecutive cycles, then done 1 cycle later, then IDLE.
- Multi-pixel: total_pix=3, base_addr=0, groups 12 cycles apart. Expect 12 writes at addresses 0..11, one done pulse after the last write, err flags 0.
- Overrun: valid_in=16'hFFFF for 2 consecutive cycles. Expect the first group written, err_overrun=1, and only 4 writes.
- Partial valid: valid_in=16'h00FF in WAIT. Expect err_partial=1, no wr_en, state WAIT; a following full valid is still accepted.
- Zero tile / restart: start with total_pix=0 gives done in the next cycle with no writes. start during DRAIN of pixel 2 (base 0x40) gives writes stopping immediately and the new tile writing from the new base_addr with pix_cnt=0.
- Async reset: assert reset for one half-cycle during DRAIN word 1. Expect all outputs at reset values immediately and no writes until the next start.
